qmaster_2908: RTL and testbench

//  QBUS DMA bus master sequencer for the QSIC, driving Am2908 DAL transceivers.

---
 rtl/qmaster_2908.sv | 230 +++++++++++++++++++++++
 tb/tb_qmaster_2908.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmaster_2908.sv
// QBUS DMA bus master sequencer: arbitrates via DMR/DMG/SACK, runs one DATI or DATO
// cycle through the Am2908 DAL transceivers with an NXM timeout, then releases the bus.
module qmaster_2908 #(
    parameter int ADDR_SETUP  = 3,
    parameter int DATA_SETUP  = 2,
    parameter int READ_SETTLE = 4,
    parameter int NXM_TIMEOUT = 200
) (
    input  logic qclk,
    input  logic RINIT_L,
    input  logic RSYNC,
    input  logic RRPLY,
    input  logic RDMR,
    input  logic RSACK,
    input  logic RDMGI,
    input  logic sRDMGI,
    input  logic RREF,
    output logic TSYNC,
    output logic TWTBT,
    output logic TDIN,
    output logic TDOUT,
    output logic TDMR,
    output logic TSACK,
    output logic TDMGO,
    input  logic dma_read,
    input  logic dma_write,
    output logic assert_addr,
    output logic assert_data,
    output logic bus_master,
    output logic dma_complete,
    output logic DALst,
    output logic DALbe,
    output logic nxm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAITBUS,
        S_ADDR,
        S_DATA,
        S_WAITRPLY,
        S_WAITNR,
        S_END
    } state_t;

    localparam logic [7:0] ADDR_LAST   = 8'(ADDR_SETUP - 1);
    localparam logic [7:0] DATA_LAST   = 8'(DATA_SETUP - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(READ_SETTLE - 1);
    localparam logic [7:0] NXM_LAST    = 8'(NXM_TIMEOUT - 1);

    state_t     state_q;
    logic       wr_q;
    logic       settle_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       rplySync1_q;
    logic       sRRPLY;

    logic tsync_q, twtbt_q, tdin_q, tdout_q, tdmr_q, tsack_q;
    logic aaddr_q, adata_q, bm_q, done_q, dalst_q, dalbe_q, nxm_q;

    // DMR is only observed through our own grant path and REF matters only for block mode.
    logic unusedInputs;
    assign unusedInputs = ^{RDMR, RSACK, RREF};

    assign cnt_d = cnt_q + 8'd1;

    // A grant arriving while we are not asking for the bus belongs to someone further down the chain.
    assign TDMGO = RDMGI & (state_q == S_IDLE);

    always_ff @(posedge qclk) begin
        if (!RINIT_L) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            settle_q    <= 1'b0;
            cnt_q       <= 8'd0;
            rplySync1_q <= 1'b0;
            sRRPLY      <= 1'b0;
            tsync_q     <= 1'b0;
            twtbt_q     <= 1'b0;
            tdin_q      <= 1'b0;
            tdout_q     <= 1'b0;
            tdmr_q      <= 1'b0;
            tsack_q     <= 1'b0;
            aaddr_q     <= 1'b0;
            adata_q     <= 1'b0;
            bm_q        <= 1'b0;
            done_q      <= 1'b0;
            dalst_q     <= 1'b0;
            dalbe_q     <= 1'b0;
            nxm_q       <= 1'b0;
        end else begin
            rplySync1_q <= RRPLY;
            sRRPLY      <= rplySync1_q;
            done_q      <= 1'b0;
            nxm_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if ((dma_read || dma_write) && !RDMGI) begin
                        wr_q    <= dma_write;
                        tdmr_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (sRDMGI) begin
                        tdmr_q  <= 1'b0;
                        tsack_q <= 1'b1;
                        bm_q    <= 1'b1;
                        state_q <= S_WAITBUS;
                    end
                end

                S_WAITBUS: begin
                    if (!RSYNC && !sRRPLY && !sRDMGI) begin
                        aaddr_q <= 1'b1;
                        dalbe_q <= 1'b1;
                        twtbt_q <= wr_q;
                        cnt_q   <= 8'd0;
                        state_q <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (cnt_q == ADDR_LAST) begin
                        tsync_q <= 1'b1;
                        aaddr_q <= 1'b0;
                        twtbt_q <= 1'b0;
                        adata_q <= wr_q;
                        dalbe_q <= wr_q;
                        cnt_q   <= 8'd0;
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_DATA: begin
                    if (!wr_q) begin
                        tdin_q   <= 1'b1;
                        cnt_q    <= 8'd0;
                        settle_q <= 1'b0;
                        state_q  <= S_WAITRPLY;
                    end else if (cnt_q == DATA_LAST) begin
                        tdout_q  <= 1'b1;
                        cnt_q    <= 8'd0;
                        settle_q <= 1'b0;
                        state_q  <= S_WAITRPLY;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                // Before RPLY the counter is the NXM timer; after a read RPLY it times the settle delay.
                S_WAITRPLY: begin
                    if (settle_q) begin
                        if (dalst_q) begin
                            dalst_q <= 1'b0;
                            tdin_q  <= 1'b0;
                            state_q <= S_WAITNR;
                        end else if (cnt_q == SETTLE_LAST) begin
                            dalst_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else if (sRRPLY) begin
                        if (wr_q) begin
                            tdout_q <= 1'b0;
                            state_q <= S_WAITNR;
                        end else begin
                            settle_q <= 1'b1;
                            cnt_q    <= 8'd1;
                        end
                    end else if (cnt_q == NXM_LAST) begin
                        tdin_q  <= 1'b0;
                        tdout_q <= 1'b0;
                        tsync_q <= 1'b0;
                        tsack_q <= 1'b0;
                        bm_q    <= 1'b0;
                        adata_q <= 1'b0;
                        dalbe_q <= 1'b0;
                        done_q  <= 1'b1;
                        nxm_q   <= 1'b1;
                        state_q <= S_END;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_WAITNR: begin
                    if (!sRRPLY) begin
                        tsync_q <= 1'b0;
                        tsack_q <= 1'b0;
                        bm_q    <= 1'b0;
                        adata_q <= 1'b0;
                        dalbe_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_END;
                    end
                end

                S_END: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign TSYNC        = tsync_q;
    assign TWTBT        = twtbt_q;
    assign TDIN         = tdin_q;
    assign TDOUT        = tdout_q;
    assign TDMR         = tdmr_q;
    assign TSACK        = tsack_q;
    assign assert_addr  = aaddr_q;
    assign assert_data  = adata_q;
    assign bus_master   = bm_q;
    assign dma_complete = done_q;
    assign DALst        = dalst_q;
    assign DALbe        = dalbe_q;
    assign nxm          = nxm_q;

endmodule

// File: tb/tb_qmaster_2908.sv
// Directed bench for qmaster_2908: a simple arbiter/slave model answers the bus cycles
// and each scenario task checks cycle-accurate event positions in a recorded trace.
`timescale 1ns/1ps
module tb_qmaster_2908;

    logic qclk = 1'b0;
    logic RINIT_L = 1'b0;
    logic RSYNC = 1'b0, RRPLY = 1'b0, RDMR = 1'b0, RSACK = 1'b0;
    logic RDMGI = 1'b0, sRDMGI = 1'b0, RREF = 1'b0;
    logic dma_read = 1'b0, dma_write = 1'b0;
    logic TSYNC, TWTBT, TDIN, TDOUT, TDMR, TSACK, TDMGO;
    logic assert_addr, assert_data, bus_master, dma_complete, DALst, DALbe, nxm;

    logic grantSync1 = 1'b0;
    logic rplyEnable = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    localparam int B_TSYNC = 0, B_TWTBT = 1, B_TDIN = 2, B_TDOUT = 3, B_TDMR = 4;
    localparam int B_TSACK = 5, B_TDMGO = 6, B_AADDR = 7, B_ADATA = 8, B_BM = 9;
    localparam int B_DONE = 10, B_DALST = 11, B_DALBE = 12, B_NXM = 13, B_RRPLY = 14;

    logic [14:0] trace [0:299];
    int traceLen = 0;

    qmaster_2908 dut (
        .qclk(qclk), .RINIT_L(RINIT_L), .RSYNC(RSYNC), .RRPLY(RRPLY), .RDMR(RDMR),
        .RSACK(RSACK), .RDMGI(RDMGI), .sRDMGI(sRDMGI), .RREF(RREF),
        .TSYNC(TSYNC), .TWTBT(TWTBT), .TDIN(TDIN), .TDOUT(TDOUT), .TDMR(TDMR),
        .TSACK(TSACK), .TDMGO(TDMGO), .dma_read(dma_read), .dma_write(dma_write),
        .assert_addr(assert_addr), .assert_data(assert_data), .bus_master(bus_master),
        .dma_complete(dma_complete), .DALst(DALst), .DALbe(DALbe), .nxm(nxm)
    );

    always #25 qclk = ~qclk;

    // Grant synchronizer, arbiter (grant 75ns after DMR, removed on SACK) and slave (RPLY 75ns after DIN/DOUT).
    always @(posedge qclk) begin
        grantSync1 <= RDMGI;
        sRDMGI     <= grantSync1;
    end

    always @(posedge TDMR) begin
        #75;
        RDMGI = 1'b1;
    end

    always @(posedge TSACK) RDMGI = 1'b0;

    always @(posedge TDIN or posedge TDOUT) begin
        if (rplyEnable) begin
            #75;
            RRPLY = 1'b1;
        end
    end

    always @(negedge TDIN or negedge TDOUT) begin
        #25;
        RRPLY = 1'b0;
    end

    function automatic logic [14:0] snap();
        return {RRPLY, nxm, DALbe, DALst, dma_complete, bus_master, assert_data,
                assert_addr, TDMGO, TSACK, TDMR, TDOUT, TDIN, TWTBT, TSYNC};
    endfunction

    function automatic int firstHigh(input int b, input int from);
        for (int k = from; k < traceLen; k++) if (trace[k][b] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int firstLow(input int b, input int from);
        for (int k = from; k < traceLen; k++) if (trace[k][b] === 1'b0) return k;
        return -1;
    endfunction

    function automatic int countBoth(input int b1, input int b2);
        int c = 0;
        for (int k = 0; k < traceLen; k++) if (trace[k][b1] === 1'b1 && trace[k][b2] === 1'b1) c++;
        return c;
    endfunction

    // Sample k holds the values just after the k-th rising edge following the call.
    task automatic recordCycles(input int n, input int rsyncRelease);
        traceLen = n;
        for (int k = 0; k < n; k++) begin
            @(posedge qclk);
            #1;
            trace[k] = snap();
            if (assert_data) dma_write = 1'b0;
            if (dma_complete) dma_read = 1'b0;
            if (k == rsyncRelease) RSYNC = 1'b0;
        end
    endtask

    task automatic test_reset;
        RINIT_L = 1'b0;
        repeat (2) @(posedge qclk);
        #1;
        vectors++;
        if (snap()[13:0] !== 14'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got %b want 0", snap()[13:0]);
        end
        @(negedge qclk);
        RINIT_L = 1'b1;
        RDMGI = 1'b1;
        #1;
        vectors++;
        if (TDMGO !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_grant_passthru got %b want 1", TDMGO);
        end
        @(posedge qclk);
        #1;
        vectors++;
        if (TDMR !== 1'b0 || TDMGO !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_grant_no_dmr got TDMR=%b TDMGO=%b want 0 1", TDMR, TDMGO);
        end
        @(negedge qclk);
        RDMGI = 1'b0;
        #1;
        vectors++;
        if (TDMGO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL grant_drop_passthru got %b want 0", TDMGO);
        end
        repeat (4) @(negedge qclk);
    endtask

    task automatic test_write;
        int tsackRise, aaRise, tsyncRise, adRise, doutRise, doutFall, rplyRise;
        rplyEnable = 1'b1;
        @(negedge qclk);
        dma_write = 1'b1;
        recordCycles(40, -1);
        tsackRise = firstHigh(B_TSACK, 0);
        aaRise    = firstHigh(B_AADDR, 0);
        tsyncRise = firstHigh(B_TSYNC, 0);
        adRise    = firstHigh(B_ADATA, 0);
        doutRise  = firstHigh(B_TDOUT, 0);
        doutFall  = firstLow(B_TDOUT, doutRise);
        rplyRise  = firstHigh(B_RRPLY, 0);

        vectors++;
        if (trace[0][B_TDMR] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wr_dmr_first got %b want 1", trace[0][B_TDMR]);
        end
        vectors++;
        if (tsackRise < 1 || trace[tsackRise][B_TDMR] !== 1'b0 || trace[tsackRise-1][B_TDMR] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wr_sack_handoff got sackAt=%0d want DMR high before and low at SACK", tsackRise);
        end
        vectors++;
        if (countBoth(B_AADDR, B_AADDR) != 3 || countBoth(B_AADDR, B_TWTBT) != 3 || countBoth(B_TWTBT, B_TWTBT) != 3) begin
            miscompares++;
            $display("[TB] FAIL wr_addr_phase got addr=%0d addr&wtbt=%0d wtbt=%0d want 3 3 3",
                     countBoth(B_AADDR, B_AADDR), countBoth(B_AADDR, B_TWTBT), countBoth(B_TWTBT, B_TWTBT));
        end
        vectors++;
        if (tsyncRise !== aaRise + 3) begin
            miscompares++;
            $display("[TB] FAIL wr_sync_pos got %0d want %0d", tsyncRise, aaRise + 3);
        end
        vectors++;
        if (doutRise !== adRise + 2) begin
            miscompares++;
            $display("[TB] FAIL wr_dout_setup got %0d want %0d", doutRise, adRise + 2);
        end
        vectors++;
        if (doutFall !== rplyRise + 2) begin
            miscompares++;
            $display("[TB] FAIL wr_dout_release got %0d want %0d", doutFall, rplyRise + 2);
        end
        vectors++;
        if (countBoth(B_DONE, B_DONE) != 1 || countBoth(B_NXM, B_NXM) != 0) begin
            miscompares++;
            $display("[TB] FAIL wr_complete got done=%0d nxm=%0d want 1 0",
                     countBoth(B_DONE, B_DONE), countBoth(B_NXM, B_NXM));
        end
        vectors++;
        if (countBoth(B_TDMR, B_TSACK) != 0 || countBoth(B_TDMGO, B_TDMGO) != 0) begin
            miscompares++;
            $display("[TB] FAIL wr_exclusive got dmr&sack=%0d dmgo=%0d want 0 0",
                     countBoth(B_TDMR, B_TSACK), countBoth(B_TDMGO, B_TDMGO));
        end
        vectors++;
        if (trace[39][B_TSACK] !== 1'b0 || trace[39][B_BM] !== 1'b0 || trace[39][B_ADATA] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_release got sack=%b bm=%b adata=%b want 0 0 0",
                     trace[39][B_TSACK], trace[39][B_BM], trace[39][B_ADATA]);
        end
        repeat (4) @(negedge qclk);
    endtask

    task automatic test_read;
        int aaRise, tsyncRise, dinRise, dinFall, dalstRise, rplyRise;
        rplyEnable = 1'b1;
        @(negedge qclk);
        dma_read = 1'b1;
        recordCycles(40, -1);
        aaRise    = firstHigh(B_AADDR, 0);
        tsyncRise = firstHigh(B_TSYNC, 0);
        dinRise   = firstHigh(B_TDIN, 0);
        dinFall   = firstLow(B_TDIN, dinRise);
        dalstRise = firstHigh(B_DALST, 0);
        rplyRise  = firstHigh(B_RRPLY, 0);

        vectors++;
        if (dinRise !== tsyncRise + 1) begin
            miscompares++;
            $display("[TB] FAIL rd_din_pos got %0d want %0d", dinRise, tsyncRise + 1);
        end
        vectors++;
        if (trace[aaRise][B_DALBE] !== 1'b1 || trace[tsyncRise][B_DALBE] !== 1'b0 || countBoth(B_TWTBT, B_TWTBT) != 0) begin
            miscompares++;
            $display("[TB] FAIL rd_dalbe got addr=%b data=%b wtbt=%0d want 1 0 0",
                     trace[aaRise][B_DALBE], trace[tsyncRise][B_DALBE], countBoth(B_TWTBT, B_TWTBT));
        end
        vectors++;
        if (dalstRise !== rplyRise + 5 || countBoth(B_DALST, B_DALST) != 1) begin
            miscompares++;
            $display("[TB] FAIL rd_dalst got at=%0d n=%0d want at=%0d n=1",
                     dalstRise, countBoth(B_DALST, B_DALST), rplyRise + 5);
        end
        vectors++;
        if (dinFall !== dalstRise + 1) begin
            miscompares++;
            $display("[TB] FAIL rd_din_release got %0d want %0d", dinFall, dalstRise + 1);
        end
        vectors++;
        if (countBoth(B_DONE, B_DONE) != 1 || countBoth(B_NXM, B_NXM) != 0 || countBoth(B_TDIN, B_TDOUT) != 0) begin
            miscompares++;
            $display("[TB] FAIL rd_complete got done=%0d nxm=%0d din&dout=%0d want 1 0 0",
                     countBoth(B_DONE, B_DONE), countBoth(B_NXM, B_NXM), countBoth(B_TDIN, B_TDOUT));
        end
        vectors++;
        if (trace[39][B_TSACK] !== 1'b0 || trace[39][B_BM] !== 1'b0 || trace[39][B_TDMR] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_release got sack=%b bm=%b dmr=%b want 0 0 0",
                     trace[39][B_TSACK], trace[39][B_BM], trace[39][B_TDMR]);
        end
        repeat (4) @(negedge qclk);
    endtask

    task automatic test_nxm;
        int dinRise, dinFall;
        rplyEnable = 1'b0;
        @(negedge qclk);
        dma_read = 1'b1;
        recordCycles(260, -1);
        dinRise = firstHigh(B_TDIN, 0);
        dinFall = firstLow(B_TDIN, dinRise);

        vectors++;
        if (dinRise < 0 || dinFall - dinRise !== 200) begin
            miscompares++;
            $display("[TB] FAIL nxm_timeout got %0d cycles want 200", dinFall - dinRise);
        end
        vectors++;
        if (trace[dinFall][B_DONE] !== 1'b1 || trace[dinFall][B_NXM] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL nxm_pulse got done=%b nxm=%b want 1 1",
                     trace[dinFall][B_DONE], trace[dinFall][B_NXM]);
        end
        vectors++;
        if (countBoth(B_DONE, B_DONE) != 1 || countBoth(B_NXM, B_NXM) != 1 || countBoth(B_DALST, B_DALST) != 0) begin
            miscompares++;
            $display("[TB] FAIL nxm_counts got done=%0d nxm=%0d dalst=%0d want 1 1 0",
                     countBoth(B_DONE, B_DONE), countBoth(B_NXM, B_NXM), countBoth(B_DALST, B_DALST));
        end
        vectors++;
        if (trace[dinFall][B_TSACK] !== 1'b0 || trace[dinFall][B_TSYNC] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nxm_release got sack=%b sync=%b want 0 0",
                     trace[dinFall][B_TSACK], trace[dinFall][B_TSYNC]);
        end
        rplyEnable = 1'b1;
        repeat (4) @(negedge qclk);
    endtask

    task automatic test_bus_busy;
        rplyEnable = 1'b1;
        @(negedge qclk);
        RSYNC = 1'b1;
        dma_read = 1'b1;
        recordCycles(60, 14);
        vectors++;
        if (trace[12][B_TSACK] !== 1'b1 || trace[12][B_BM] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_sack got sack=%b bm=%b want 1 1", trace[12][B_TSACK], trace[12][B_BM]);
        end
        vectors++;
        if (firstHigh(B_AADDR, 0) !== 15) begin
            miscompares++;
            $display("[TB] FAIL busy_addr_wait got %0d want 15", firstHigh(B_AADDR, 0));
        end
        vectors++;
        if (countBoth(B_DONE, B_DONE) != 1) begin
            miscompares++;
            $display("[TB] FAIL busy_complete got %0d want 1", countBoth(B_DONE, B_DONE));
        end
        repeat (4) @(negedge qclk);
    endtask

    task automatic test_reset_midcycle;
        int waited = 0;
        int doneSeen = 0;
        int dmrSeen = 0;
        rplyEnable = 1'b0;
        @(negedge qclk);
        dma_read = 1'b1;
        while (TDIN !== 1'b1 && waited < 40) begin
            @(posedge qclk);
            #1;
            waited++;
        end
        vectors++;
        if (TDIN !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_reach_din got %b want 1 within 40 cycles", TDIN);
        end
        repeat (5) @(posedge qclk);
        @(negedge qclk);
        RINIT_L = 1'b0;
        dma_read = 1'b0;
        @(posedge qclk);
        #1;
        vectors++;
        if (snap()[13:0] !== 14'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_outputs got %b want 0", snap()[13:0]);
        end
        @(negedge qclk);
        RINIT_L = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge qclk);
            #1;
            if (dma_complete === 1'b1) doneSeen++;
            if (TDMR === 1'b1) dmrSeen++;
        end
        vectors++;
        if (doneSeen != 0 || dmrSeen != 0) begin
            miscompares++;
            $display("[TB] FAIL midrst_no_complete got done=%0d dmr=%0d want 0 0", doneSeen, dmrSeen);
        end
        rplyEnable = 1'b1;
    endtask

    initial begin
        $display("[TB] qmaster_2908 directed test start");
        test_reset;
        test_write;
        test_read;
        test_nxm;
        test_bus_busy;
        test_reset_midcycle;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
